// File: rtl/delay_timer_pkg.sv
// Shared types and defaults for the multi-channel delay/interval timer.
package delay_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    localparam int DEF_CBITS      = 13;
    localparam int DEF_DEF_PERIOD = 5000;

endpackage

// File: rtl/delay_timer_chan.sv
// One timer channel: start/stop/pause FSM, terminal counter, registered tick, sticky overrun error.
module delay_timer_chan
    import delay_timer_pkg::*;
#(
    parameter int CBITS      = DEF_CBITS,
    parameter int DEF_PERIOD = DEF_DEF_PERIOD,
    parameter int USE_DEF    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_pause,
    input  logic             i_mode,
    input  logic [CBITS-1:0] i_period,
    input  logic             i_err_clr,
    output logic             o_tick,
    output logic             o_tick_nxt,
    output logic             o_busy,
    output logic [CBITS-1:0] o_cnt,
    output logic             o_err
);

    state_t           r_state, w_state_nxt;
    logic [CBITS-1:0] r_cnt, w_cnt_nxt;
    logic [CBITS-1:0] r_period_q, w_period_nxt, w_period_eff;
    logic             r_mode_q, w_mode_nxt;
    logic             r_tick, w_tick_nxt;
    logic             r_busy, r_err, w_err_nxt;

    always_comb begin
        w_period_eff = i_period;
        if (USE_DEF != 0 && i_period == '0) begin
            w_period_eff = CBITS'(DEF_PERIOD);
        end
    end

    // Priority stop > start > pause > count; leaving HOLD resumes counting on the same edge.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_period_nxt = r_period_q;
        w_mode_nxt   = r_mode_q;
        w_tick_nxt   = 1'b0;
        if (i_stop) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (i_start) begin
            w_state_nxt  = RUN;
            w_cnt_nxt    = '0;
            w_period_nxt = w_period_eff;
            w_mode_nxt   = i_mode;
        end else begin
            case (r_state)
                RUN, HOLD: begin
                    if (i_pause) begin
                        w_state_nxt = HOLD;
                    end else begin
                        w_state_nxt = RUN;
                        if (r_cnt == r_period_q) begin
                            w_tick_nxt = 1'b1;
                            w_cnt_nxt  = '0;
                            if (r_mode_q == MODE_PERIODIC) begin
                                w_period_nxt = w_period_eff;
                            end else begin
                                w_state_nxt = IDLE;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Overrun is a safety net only; a set in the same cycle as a clear wins.
    assign w_err_nxt = (r_cnt > r_period_q) | (r_err & ~i_err_clr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_period_q <= '0;
            r_mode_q   <= MODE_ONESHOT;
            r_tick     <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_period_q <= w_period_nxt;
            r_mode_q   <= w_mode_nxt;
            r_tick     <= w_tick_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_err      <= w_err_nxt;
        end
    end

    assign o_tick     = r_tick;
    assign o_tick_nxt = w_tick_nxt;
    assign o_busy     = r_busy;
    assign o_cnt      = r_cnt;
    assign o_err      = r_err;

endmodule

// File: rtl/delay_timer_mc.sv
// Multi-channel programmable delay/interval timer: NCH independent channels plus a registered OR of ticks.
module delay_timer_mc
    import delay_timer_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CBITS      = DEF_CBITS,
    parameter int DEF_PERIOD = DEF_DEF_PERIOD,
    parameter int USE_DEF    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       start,
    input  logic [NCH-1:0]       stop,
    input  logic [NCH-1:0]       pause,
    input  logic [NCH-1:0]       mode,
    input  logic [NCH*CBITS-1:0] period,
    input  logic [NCH-1:0]       err_clr,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       busy,
    output logic [NCH*CBITS-1:0] cnt,
    output logic [NCH-1:0]       err,
    output logic                 any_tick
);

    logic [NCH-1:0] w_tick_nxt;
    logic           r_any_tick;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        delay_timer_chan #(
            .CBITS      (CBITS),
            .DEF_PERIOD (DEF_PERIOD),
            .USE_DEF    (USE_DEF)
        ) u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_start    (start[g]),
            .i_stop     (stop[g]),
            .i_pause    (pause[g]),
            .i_mode     (mode[g]),
            .i_period   (period[g*CBITS +: CBITS]),
            .i_err_clr  (err_clr[g]),
            .o_tick     (tick[g]),
            .o_tick_nxt (w_tick_nxt[g]),
            .o_busy     (busy[g]),
            .o_cnt      (cnt[g*CBITS +: CBITS]),
            .o_err      (err[g])
        );
    end

    // Built from the channels' next-tick terms so it rises on the same edge as tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any_tick <= 1'b0;
        end else begin
            r_any_tick <= |w_tick_nxt;
        end
    end

    assign any_tick = r_any_tick;

endmodule

// File: tb/tb_delay_timer_mc.sv
// Directed bench for delay_timer_mc with hand-computed expectations.
module tb_delay_timer_mc;

    localparam int NCH   = 4;
    localparam int CBITS = 13;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH-1:0]       start, stop, pause, mode, err_clr;
    logic [CBITS-1:0]     per [NCH];
    logic [NCH*CBITS-1:0] period;
    logic [NCH-1:0]       tick, busy, err;
    logic [NCH*CBITS-1:0] cnt;
    logic                 any_tick;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign period = {per[3], per[2], per[1], per[0]};

    delay_timer_mc #(
        .NCH        (NCH),
        .CBITS      (CBITS),
        .DEF_PERIOD (5000),
        .USE_DEF    (1)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .pause    (pause),
        .mode     (mode),
        .period   (period),
        .err_clr  (err_clr),
        .tick     (tick),
        .busy     (busy),
        .cnt      (cnt),
        .err      (err),
        .any_tick (any_tick)
    );

    function automatic logic [31:0] cnt_of(input int ch);
        return 32'(cnt[ch*CBITS +: CBITS]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input int ch, input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (tick[ch] !== 1'b1 && n < max);
    endtask

    int n, nt;
    logic bh;

    initial begin
        rst_n = 1'b0;
        start = '0; stop = '0; pause = '0; mode = '0; err_clr = '0;
        for (int i = 0; i < NCH; i++) per[i] = '0;
        repeat (3) step();
        check("rst_tick", 32'(tick), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_err", 32'(err), 0);
        check("rst_cnt", 32'(cnt == '0), 1);
        check("rst_any", 32'(any_tick), 0);
        rst_n = 1'b1;
        step();

        // one-shot ch0, P=3
        per[0] = 3; mode[0] = 1'b0; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        check("os_cnt0", cnt_of(0), 0);
        check("os_busy", 32'(busy[0]), 1);
        for (int k = 1; k <= 3; k++) begin
            step();
            check("os_cnt", cnt_of(0), 32'(k));
            check("os_notick", 32'(tick[0]), 0);
        end
        step();
        check("os_tick", 32'(tick[0]), 1);
        check("os_any", 32'(any_tick), 1);
        check("os_idle", 32'(busy[0]), 0);
        nt = 0;
        repeat (10) begin step(); nt += int'(tick[0]); end
        check("os_single", 32'(nt), 0);

        // periodic ch1, P=4, then P=2 mid-interval
        per[1] = 4; mode[1] = 1'b1; start[1] = 1'b1;
        step();
        start[1] = 1'b0;
        nt = 0; bh = 1'b1;
        repeat (20) begin step(); nt += int'(tick[1]); bh &= busy[1]; end
        check("per_ticks", 32'(nt), 4);
        check("per_busy", 32'(bh), 1);
        step(); step();
        check("per_cnt2", cnt_of(1), 2);
        per[1] = 2;
        wait_tick(1, 20, n); check("per_old_gap", 32'(n), 3);
        wait_tick(1, 20, n); check("per_new_gap1", 32'(n), 3);
        wait_tick(1, 20, n); check("per_new_gap2", 32'(n), 3);
        stop[1] = 1'b1; step(); stop[1] = 1'b0;
        check("per_stop", 32'(busy[1]), 0);

        // pause ch2, P=10, held 7 cycles at cnt=5
        per[2] = 10; mode[2] = 1'b1; start[2] = 1'b1;
        step();
        start[2] = 1'b0;
        repeat (5) step();
        check("pz_cnt5", cnt_of(2), 5);
        pause[2] = 1'b1;
        repeat (7) step();
        check("pz_hold", cnt_of(2), 5);
        check("pz_busy", 32'(busy[2]), 1);
        pause[2] = 1'b0;
        wait_tick(2, 30, n);
        check("pz_delay", 32'(n), 6);
        stop[2] = 1'b1; step(); stop[2] = 1'b0;

        // ch3: start+stop together, then restart alone
        per[3] = 10; mode[3] = 1'b1; start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        repeat (6) step();
        check("ss_cnt6", cnt_of(3), 6);
        start[3] = 1'b1; stop[3] = 1'b1;
        step();
        start[3] = 1'b0; stop[3] = 1'b0;
        check("ss_busy", 32'(busy[3]), 0);
        check("ss_cnt", cnt_of(3), 0);
        check("ss_tick", 32'(tick[3]), 0);
        nt = 0;
        repeat (15) begin step(); nt += int'(tick[3]); end
        check("ss_quiet", 32'(nt), 0);
        start[3] = 1'b1; step(); start[3] = 1'b0;
        repeat (6) step();
        check("rs_cnt6", cnt_of(3), 6);
        start[3] = 1'b1; step(); start[3] = 1'b0;
        check("rs_cnt0", cnt_of(3), 0);
        wait_tick(3, 30, n);
        check("rs_full", 32'(n), 11);
        stop[3] = 1'b1; step(); stop[3] = 1'b0;

        // default period and maximum period on ch0
        per[0] = 0; mode[0] = 1'b0; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        wait_tick(0, 6000, n);
        check("def_period", 32'(n), 5001);
        per[0] = 13'd8191; start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        check("max_cnt0", cnt_of(0), 0);
        wait_tick(0, 9000, n);
        check("max_period", 32'(n), 8192);
        check("max_noerr", 32'(err), 0);
        check("max_idle", 32'(busy[0]), 0);

        // asynchronous reset mid-count on all channels
        for (int i = 0; i < NCH; i++) per[i] = 20;
        mode = '1; start = '1;
        step();
        start = '0;
        repeat (7) step();
        check("ar_cnt7", cnt_of(2), 7);
        #3 rst_n = 1'b0;
        #1;
        check("ar_busy", 32'(busy), 0);
        check("ar_cnt", 32'(cnt == '0), 1);
        check("ar_tick", 32'(tick), 0);
        step();
        rst_n = 1'b1;
        nt = 0;
        repeat (30) begin step(); nt += int'(any_tick); end
        check("ar_quiet", 32'(nt), 0);
        check("ar_idle", 32'(busy), 0);

        // forced overrun on ch3
        per[3] = 10; mode[3] = 1'b1; start[3] = 1'b1;
        step();
        start[3] = 1'b0;
        repeat (2) step();
        check("er_pre", 32'(err[3]), 0);
        force u_dut.g_ch[3].u_chan.r_cnt = 13'd100;
        step();
        release u_dut.g_ch[3].u_chan.r_cnt;
        check("er_set", 32'(err[3]), 1);
        stop[3] = 1'b1; step(); stop[3] = 1'b0;
        repeat (3) step();
        check("er_sticky", 32'(err[3]), 1);
        err_clr[3] = 1'b1; err_clr[2] = 1'b1;
        step();
        err_clr = '0;
        check("er_clr", 32'(err[3]), 0);
        check("er_clr_noset", 32'(err[2]), 0);
        start[3] = 1'b1; step(); start[3] = 1'b0;
        force u_dut.g_ch[3].u_chan.r_cnt = 13'd100;
        err_clr[3] = 1'b1;
        step();
        err_clr[3] = 1'b0;
        release u_dut.g_ch[3].u_chan.r_cnt;
        check("er_set_wins", 32'(err[3]), 1);
        stop[3] = 1'b1; step(); stop[3] = 1'b0;
        err_clr[3] = 1'b1; step(); err_clr[3] = 1'b0;
        check("er_clr2", 32'(err[3]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
